// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the tick divisor rounding rule.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_OS = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int os_div(input int clk_freq, input int baud);
        return (clk_freq + baud * (UART_OS / 2)) / (baud * UART_OS);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver line/byte bundle.
//   rx        : serial line into the receiver (idle high)
//   doutrx    : last received byte
//   donerx    : one-cycle strobe when doutrx/frame_err update
//   frame_err : stop bit of last frame was low
//   busy      : a frame is being received
// master = the receiver, slave = whoever drives the line and consumes bytes.
interface uart_rx_os_if;
    logic       rx;
    logic [7:0] doutrx;
    logic       donerx;
    logic       frame_err;
    logic       busy;

    modport master (input rx, output doutrx, donerx, frame_err, busy);
    modport slave  (output rx, input doutrx, donerx, frame_err, busy);
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: tick is high for one clk every DIV clocks.
//   clk  : clock
//   rst  : synchronous active-low reset
//   clr  : restart the divider; the next tick comes DIV clocks later
//   tick : one-cycle pulse
module uart_os_tick #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 UART receiver with 3-sample majority vote,
// false-start rejection and stop-bit framing check.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : uart_rx_os_if.master (rx in; doutrx, donerx, frame_err, busy out)
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1843200,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input logic          clk,
    input logic          rst,
    uart_rx_os_if.master bus
);
    localparam int DIV = os_div(CLK_FREQ, BAUD);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("uart_rx_os: tick divisor must be at least 2");
        end
        if (OVERSAMPLE != UART_OS) begin : g_os_chk
            $error("uart_rx_os: only 16x oversampling is supported");
        end
    endgenerate

    rx_state_t  state;
    logic       rx_s1, rxs, rxs_d;
    logic       armed;
    logic [7:0] os_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [1:0] samp;
    logic [7:0] dout_q;
    logic       done_q, ferr_q, busy_q;
    logic       tick, start_det, maj, vote;

    assign start_det = (state == IDLE) && armed && rxs_d && !rxs;
    // samp[0]/samp[1] hold ticks 7/8; tick 9 is the live rxs.
    assign maj  = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
    assign vote = tick && (os_cnt[3:0] == 4'd9);

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rx_s1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            armed   <= 1'b1;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            samp    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_s1  <= bus.rx;
            rxs    <= rx_s1;
            rxs_d  <= rxs;
            done_q <= 1'b0;
            if (rxs)
                armed <= 1'b1;

            if (tick) begin
                os_cnt <= os_cnt + 8'd1;
                if (os_cnt[3:0] == 4'd7) samp[0] <= rxs;
                if (os_cnt[3:0] == 4'd8) samp[1] <= rxs;
            end

            case (state)
                IDLE: if (start_det) begin
                    state  <= START;
                    os_cnt <= '0;
                    busy_q <= 1'b1;
                end
                START: if (vote) begin
                    if (maj) begin
                        // line went back high: glitch, not a start bit
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: if (vote) begin
                    shreg   <= {maj, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state <= STOP;
                end
                STOP: if (vote) begin
                    dout_q <= shreg;
                    ferr_q <= ~maj;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    // a low stop bit blocks retrigger until the line idles high
                    if (!maj)
                        armed <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.doutrx    = dout_q;
    assign bus.donerx    = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_os_if bus ();

    uart_rx_os #(.CLK_FREQ(1843200), .BAUD(9600), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_fall = 0;
    int last_done_cyc = 0;
    int done_cnt = 0;
    int n_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [7:0] din;
        int         per;
        logic       stop;
        int         gap;
        logic [7:0] exp_d;
        logic       exp_fe;
    } vec_t;
    vec_t tbl[6];

    // ---------------- monitor / scoreboard ----------------
    logic       prev_done = 1'b0;
    logic       rst_prev  = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    logic       prev_fe   = 1'b0;
    exp_t       e;

    always @(negedge clk) begin
        if (bus.donerx) begin
            last_done_cyc = cyc;
            done_cnt++;
            if (prev_done) begin
                checks++; failures++;
                $display("FAIL donerx_width: donerx high 2 cycles, required 1");
            end
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_donerx: got dout=%h fe=%b, required no strobe",
                         bus.doutrx, bus.frame_err);
            end else begin
                e = q.pop_front();
                if (bus.doutrx !== e.d || bus.frame_err !== e.fe) begin
                    failures++;
                    $display("FAIL rx_byte: got dout=%h fe=%b, required dout=%h fe=%b",
                             bus.doutrx, bus.frame_err, e.d, e.fe);
                end
            end
        end else if (rst && rst_prev &&
                     (bus.doutrx !== prev_dout || bus.frame_err !== prev_fe)) begin
            checks++; failures++;
            $display("FAIL output_hold: dout=%h fe=%b changed without donerx, required %h %b",
                     bus.doutrx, bus.frame_err, prev_dout, prev_fe);
        end
        prev_done = bus.donerx;
        prev_dout = bus.doutrx;
        prev_fe   = bus.frame_err;
        rst_prev  = rst;
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe);
        q.push_back({d, fe});
        n_exp++;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One 8N1 frame, one loop pass per clock. noise inverts a 12-clock window
    // around sample tick 8 of every data cell; rst_at pulses reset at that offset.
    task automatic send(input logic [7:0] d, input int per, input logic stop,
                        input bit noise, input int rst_at);
        int   b, o;
        logic v;
        t_fall = cyc;
        for (int c = 0; c < 10 * per; c++) begin
            b = c / per;
            o = c % per;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop;
            else             v = d[b-1];
            if (noise && b >= 1 && b <= 8 && o >= 102 && o <= 113) v = ~v;
            bus.rx = v;
            if (c == rst_at)     rst = 1'b0;
            if (c == rst_at + 1) rst = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 4000) begin @(posedge clk); #1; n++; end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d frames pending, required 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        tbl[0] = '{8'hA5, 192, 1'b1, 40, 8'hA5, 1'b0};
        tbl[1] = '{8'h00, 192, 1'b1, 40, 8'h00, 1'b0};
        tbl[2] = '{8'hFF, 185, 1'b1, 40, 8'hFF, 1'b0};
        tbl[3] = '{8'h55, 199, 1'b1, 40, 8'h55, 1'b0};
        tbl[4] = '{8'hC3, 192, 1'b0, 40, 8'hC3, 1'b1};
        tbl[5] = '{8'h3E, 185, 1'b1, 40, 8'h3E, 1'b0};

        // reset
        bus.rx = 1'b1;
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("rst_doutrx", int'(bus.doutrx), 0);
        check("rst_donerx", int'(bus.donerx), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b1;
        idle(500);

        // table-driven frames, with start-to-donerx latency
        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].exp_d, tbl[i].exp_fe);
            send(tbl[i].din, tbl[i].per, tbl[i].stop, 1'b0, -1);
            idle(tbl[i].gap);
            drain("table");
            checks++;
            if (last_done_cyc - t_fall < 1850 || last_done_cyc - t_fall > 1854) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d clk, required 1852+-2",
                         i, last_done_cyc - t_fall);
            end
        end

        // 48-clock glitch on idle line
        bus.rx = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            @(posedge clk); #1;
            if (k == 48)  bus.rx = 1'b1;
            if (k == 10)  check("glitch_busy_hi", int'(bus.busy), 1);
            if (k == 124) check("glitch_busy_lo", int'(bus.busy), 0);
        end
        idle(200);

        // inverted pulse on the middle sample of every data cell
        push_exp(8'h3C, 1'b0);
        send(8'h3C, 192, 1'b1, 1'b1, -1);
        idle(40);
        drain("noise");

        // low stop bit then held low for 3 frames: one error frame only
        push_exp(8'h81, 1'b1);
        send(8'h81, 192, 1'b0, 1'b0, -1);
        bus.rx = 1'b0;
        repeat (3 * 1920) begin @(posedge clk); #1; end
        drain("ferr");
        idle(50);
        push_exp(8'h5A, 1'b0);
        send(8'h5A, 192, 1'b1, 1'b0, -1);
        idle(40);
        drain("after_break");

        // true break from idle
        push_exp(8'h00, 1'b1);
        bus.rx = 1'b0;
        repeat (3 * 1920) begin @(posedge clk); #1; end
        idle(50);
        drain("break");

        // reset during data bit 4: no output for that frame
        send(8'hFF, 192, 1'b1, 1'b0, 5 * 192 + 50);
        idle(40);
        check("midrst_doutrx", int'(bus.doutrx), 0);
        check("midrst_frame_err", int'(bus.frame_err), 0);
        push_exp(8'h12, 1'b0);
        send(8'h12, 192, 1'b1, 1'b0, -1);
        idle(40);
        drain("midrst");

        // back-to-back with per-frame bit period jitter
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            int         per;
            d   = 8'($urandom_range(0, 255));
            per = 185 + int'($urandom_range(0, 14));
            push_exp(d, 1'b0);
            send(d, per, 1'b1, 1'b0, -1);
        end
        idle(100);
        drain("b2b");

        check("donerx_total", done_cnt, n_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: recovers 8N1 frames from the serial `rx` line using a 16x sample tick, a 3-sample majority vote per bit, false-start rejection and stop-bit framing check. It pairs with the `UART_top` transmit path, and is its robust receive counterpart for links whose line is asynchronous to `clk`. Output is a parallel byte, a one-cycle `donerx` strobe and a framing-error flag.

## Interface
- `CLK_FREQ`, 1843200: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: sample ticks per bit. Fixed at 16; other values are unsupported.
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-low.
- `rx` input 1: asynchronous serial line. Idle high.
- `doutrx` output 8: last received byte, LSB first on the line. Holds its value until the next frame completes.
- `donerx` output 1: one-cycle pulse when `doutrx`/`frame_err` update.
- `frame_err` output 1: stop bit of the last frame sampled low. Valid with `donerx` and held until the next `donerx`.
- `busy` output 1: high from start detection until return to IDLE.

## Operation
- **Input synchronizer.** `rx` passes through 2 flops, reset value 1. Every later stage uses the synchronized `rxs`.
- **Tick divisor.** `DIV = (CLK_FREQ + BAUD*8) / (BAUD*16)`, integer arithmetic, rounded to nearest. `DIV` must be ≥ 2; this is an elaboration-time assertion. Defaults give `DIV = 12`, so one bit lasts 192 clocks.
- **Tick generator.** `tick` pulses for 1 clk every `DIV` clocks. The divider is cleared on start detection, so tick 0 occurs `DIV` clocks after the falling edge is seen.
- **Bit-cell sampling.** `os_cnt` (8 bits) counts ticks since start detection. Bit cell n covers ticks 16n .. 16n+15. Samples are taken at ticks 16n+7, 16n+8 and 16n+9; the bit value is the majority of the three, decided at tick 16n+9.
- **States:**
  - IDLE: wait for `armed` && a `rxs` 1→0 transition. Then go to START and clear `os_cnt`/divider.
  - START: at tick 9, if the majority is 1 (glitch), go to IDLE with no output change. Otherwise go to DATA with `bit_idx = 0`.
  - DATA: at each tick 16(bit_idx+1)+9, shift the majority into shreg MSB (right shift, LSB first). After `bit_idx = 7`, go to STOP.
  - STOP: at tick 153 (bit 9), load `doutrx <= shreg`, set `frame_err <= ~majority`, pulse `donerx`, then go to IDLE.
- **Rearm rule.**
  - `armed` is set at reset, and cleared when a frame ends with `frame_err`.
  - `armed` is set again after `rxs` has been high for 1 clk.
  - A break (line held low) therefore produces exactly one frame with `frame_err=1`, `doutrx=8'h00` and no retrigger.
- **Back-to-back frames.** A new start edge is accepted in the first IDLE cycle after the stop decision. Stop-bit tail ticks 154..159 are not required.
- **Reset mid-frame.** `rst=0` on any edge returns to IDLE and forces all outputs to their reset values. No `donerx` is produced for the partial frame.

## Timing
- Reset values: `doutrx=8'h00`, `donerx=0`, `frame_err=0`, `busy=0`, state IDLE, `armed=1`, sync flops = 1.
- **Detection latency.** Start edge is detected 3 clk after the `rx` falling edge: 2 sync flops plus 1 edge register.
- **Output latency.** `donerx` rises 1 clk after the tick-153 decision. That is about `3 + 154*DIV + 1` clocks after the `rx` falling edge, which is 1852 clk with defaults.
- **Output update.** `doutrx` and `frame_err` change only in the same cycle as `donerx`.
- **`busy`.** Rises the cycle after start detection. Falls in the same cycle as `donerx`, or the cycle after a glitch rejection.
- **Clock tolerance.** Majority window centre sits at 8.5/16 of each bit. This tolerates ±4% combined clock error over 9.5 bits.
- **Pulse width.** `donerx` is never high for 2 consecutive cycles.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
  - Constant `UART_OS = 16`.
  - Function `os_div(clk_freq, baud)` implementing the rounding rule above.
- Sub-module `uart_os_tick`:
  - Parameters: `DIV`.
  - Ports: `clk`, `rst`, `clr`, `tick`.
  - This sub-module is natural and is shared with any future oversampling TX.
- Top `uart_rx_os` holds the synchronizer, the FSM, `os_cnt`, the majority vote and the output registers.

## Test plan
- **Reset.** Hold `rst=0` for 5 clk → all outputs 0, `busy=0`. Release, idle line for 500 clk → no `donerx`.
- **Single byte.** Drive 8N1 `0xA5` at 192 clk/bit → exactly one `donerx` pulse 1852±2 clk after the start edge, `doutrx=0xA5`, `frame_err=0`.
- **Glitch and noise.**
  - A 4-tick (48 clk) low glitch on idle `rx` → no `donerx`, `busy` low again by clk 3+10*12+1.
  - A single-tick inverted pulse at sample tick 16n+8 inside `0x3C` → still `0x3C`.
- **Framing error and break.**
  - Stop bit driven low for byte `0x81` → `doutrx=0x81`, `frame_err=1`.
  - Line then held low for 3 frame times → no further `donerx` until `rx` goes high and a new valid frame `0x5A` arrives → `frame_err=0`.
- **Back-to-back.** 10 random bytes with zero idle between stop and next start, bit period 192±7 clk (±3.6%) → 10 `donerx` pulses with matching data.
- **Reset mid-frame.** Assert `rst=0` for 1 clk during DATA bit 4 of `0xFF` → no `donerx` for that frame. The next frame `0x12` is received correctly.
